// File: rtl/aes_inv_key_store.sv
// AES-128 round-key store: expands a cipher key into 11 round keys, then streams them round 10 down to round 0.
// Latency: key_ready 10 cycles after the kld edge; first round key valid the cycle after the rd_start edge.
// Backpressure: rk_out/rk_round/rk_last hold while rk_ready=0; kld aborts any stream and restarts expansion.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as a^254 (0 maps to 0), then the AES affine transform.
    always_comb begin
        inv = a;
        for (int i = 0; i < 6; i++) begin
            inv = gf_mul(gf_mul(inv, inv), a);
        end
        inv = gf_mul(inv, inv);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_key_store #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kld,
    input  logic [KW-1:0] key,
    output logic          key_ready,
    input  logic          rd_start,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [KW-1:0] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_last,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    exp_cnt;
    logic [3:0]    idx;
    logic [KW-1:0] rk [0:NR];
    logic [KW-1:0] prev_rk;
    logic [KW-1:0] next_rk;
    logic [31:0]   w3_rot;
    logic [31:0]   sub_w;
    logic [31:0]   t_word;
    logic [7:0]    rcon;

    always_comb begin
        rcon = 8'h00;
        case (exp_cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign prev_rk = rk[exp_cnt - 4'd1];
    assign w3_rot  = {prev_rk[23:0], prev_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (w3_rot[8*g +: 8]),
            .y (sub_w[8*g +: 8])
        );
    end

    // Each new word chains off the word just produced to its left.
    always_comb begin
        t_word          = sub_w ^ {rcon, 24'h000000};
        next_rk[127:96] = prev_rk[127:96] ^ t_word;
        next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
    end

    always_comb begin
        state_nxt = state;
        if (kld) begin
            state_nxt = EXPAND;
        end else begin
            case (state)
                EXPAND:  if (exp_cnt == LAST_RND) state_nxt = READY;
                READY:   if (rd_start) state_nxt = STREAM;
                STREAM:  if (rk_ready && idx == 4'd0) state_nxt = READY;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_cnt <= 4'd0;
            idx     <= 4'd0;
        end else if (kld) begin
            exp_cnt <= 4'd1;
        end else begin
            case (state)
                EXPAND:  exp_cnt <= exp_cnt + 4'd1;
                READY:   if (rd_start) idx <= LAST_RND;
                STREAM:  if (rk_ready && idx != 4'd0) idx <= idx - 4'd1;
                default: ;
            endcase
        end
    end

    // Key storage carries no reset; key_ready (derived from state) qualifies it.
    always_ff @(posedge clk) begin
        if (kld)                  rk[0]       <= key;
        else if (state == EXPAND) rk[exp_cnt] <= next_rk;
    end

    assign rk_valid  = (state == STREAM);
    assign key_ready = (state == READY) || (state == STREAM);
    assign busy      = (state == EXPAND) || (state == STREAM);
    assign rk_out    = rk_valid ? rk[idx] : '0;
    assign rk_round  = rk_valid ? idx : 4'd0;
    assign rk_last   = rk_valid && (idx == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_store.sv
// Directed bench for aes_inv_key_store using the FIPS-197 key schedule vectors.
module tb_aes_inv_key_store;
    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic         key_ready;
    logic         rd_start;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] key2;
    logic [127:0] key2_r10;

    always #5 clk = ~clk;

    aes_inv_key_store dut (
        .clk       (clk),
        .rst       (rst),
        .kld       (kld),
        .key       (key),
        .key_ready (key_ready),
        .rd_start  (rd_start),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; kld = 1'b1; rd_start = 1'b1; rk_ready = 1'b1; key = '1;
        tick; tick;
        n_checks++;
        if ({key_ready, rk_valid, rk_last, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got kr/v/l/b=%b required 0000", {key_ready, rk_valid, rk_last, busy});
        end
        n_checks++;
        if (rk_round !== 4'd0 || rk_out !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got round=%0d out=%h required 0/0", rk_round, rk_out);
        end
        rst = 1'b1; kld = 1'b0;
        tick; tick; tick;
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rdstart: got v=%b busy=%b kr=%b required 0/0/0", rk_valid, busy, key_ready);
        end
        rd_start = 1'b0;
    endtask

    task automatic test_expand;
        int cnt;
        key = fips_rk[0]; kld = 1'b1;
        tick;
        kld = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL expand_start: got busy=%b kr=%b required 1/0", busy, key_ready);
        end
        cnt = 0;
        while (!key_ready && cnt < 20) begin
            tick;
            cnt++;
        end
        n_checks++;
        if (cnt !== 10) begin
            n_fail++;
            $display("FAIL expand_latency: got %0d cycles required 10", cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL expand_done_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_stream(input string name, input bit poke_rd);
        int xfers;
        int cyc;
        rk_ready = 1'b1; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        xfers = 0; cyc = 0;
        while (xfers < 11 && cyc < 30) begin
            rd_start = (poke_rd && xfers == 5);
            if (rk_valid) begin
                n_checks++;
                if (rk_round !== 4'(10 - xfers) || rk_out !== fips_rk[10 - xfers]
                    || rk_last !== (xfers == 10)) begin
                    n_fail++;
                    $display("FAIL %s_xfer%0d: got round=%0d last=%b out=%h required round=%0d last=%b out=%h",
                             name, xfers, rk_round, rk_last, rk_out, 10 - xfers, (xfers == 10), fips_rk[10 - xfers]);
                end
                xfers++;
            end
            cyc++;
            tick;
        end
        rd_start = 1'b0;
        n_checks++;
        if (cyc !== 11 || xfers !== 11) begin
            n_fail++;
            $display("FAIL %s_cycles: got %0d xfers in %0d cycles required 11 in 11", name, xfers, cyc);
        end
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: got v=%b busy=%b kr=%b last=%b required 0/0/1/0", name, rk_valid, busy, key_ready, rk_last);
        end
    endtask

    task automatic test_backpressure;
        int           expect_rnd;
        int           cyc;
        bit           stalled;
        logic [127:0] hold_out;
        logic [3:0]   hold_rnd;
        rk_ready = 1'b0; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        expect_rnd = 10; cyc = 0; stalled = 1'b0;
        hold_out = '0; hold_rnd = '0;
        while (expect_rnd >= 0 && cyc < 300) begin
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_valid) begin
                if (stalled) begin
                    n_checks++;
                    if (rk_out !== hold_out || rk_round !== hold_rnd) begin
                        n_fail++;
                        $display("FAIL bp_stable: got round=%0d out=%h required round=%0d out=%h",
                                 rk_round, rk_out, hold_rnd, hold_out);
                    end
                end
                if (rk_ready) begin
                    n_checks++;
                    if (rk_round !== 4'(expect_rnd) || rk_out !== fips_rk[expect_rnd]) begin
                        n_fail++;
                        $display("FAIL bp_xfer: got round=%0d out=%h required round=%0d out=%h",
                                 rk_round, rk_out, expect_rnd, fips_rk[expect_rnd]);
                    end
                    expect_rnd--;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    hold_out = rk_out;
                    hold_rnd = rk_round;
                end
            end
            cyc++;
            tick;
        end
        rk_ready = 1'b1;
        n_checks++;
        if (expect_rnd !== -1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_complete: got next_round=%0d v=%b required -1/0", expect_rnd, rk_valid);
        end
    endtask

    task automatic test_abort_rekey;
        int cyc;
        int xfers;
        rk_ready = 1'b1; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        cyc = 0;
        while (!(rk_valid && rk_round == 4'd6) && cyc < 20) begin
            tick;
            cyc++;
        end
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL abort_reach6: got %0d cycles required 4", cyc);
        end
        kld = 1'b1; key = key2;
        tick;
        kld = 1'b0;
        n_checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: got v=%b kr=%b busy=%b required 0/0/1", rk_valid, key_ready, busy);
        end
        tick; tick;
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        n_checks++;
        if (rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL expand_rdstart: got v=%b required 0", rk_valid);
        end
        cyc = 0;
        while (!key_ready && cyc < 20) begin
            tick;
            cyc++;
        end
        n_checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rekey_ready: got kr=%b v=%b required 1/0", key_ready, rk_valid);
        end
        rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        n_checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_out !== key2_r10) begin
            n_fail++;
            $display("FAIL rekey_r10: got v=%b round=%0d out=%h required 1/10/%h", rk_valid, rk_round, rk_out, key2_r10);
        end
        xfers = 0; cyc = 0;
        while (!(rk_valid && rk_last) && cyc < 30) begin
            if (rk_valid) xfers++;
            tick;
            cyc++;
        end
        n_checks++;
        if (rk_out !== key2 || rk_round !== 4'd0 || xfers !== 10) begin
            n_fail++;
            $display("FAIL rekey_r0: got round=%0d prior=%0d out=%h required 0/10/%h", rk_round, xfers, rk_out, key2);
        end
        tick;
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key2        = 128'h000102030405060708090a0b0c0d0e0f;
        key2_r10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        test_reset;
        test_expand;
        test_stream("b2b", 1'b0);
        test_backpressure;
        test_stream("replay", 1'b1);
        test_abort_rekey;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_store.md
Name: aes_inv_key_store

Overview:
- Round-key store and reverse-order reader for the AES-128 decryption path; the counterpart of the forward cipher's on-the-fly key schedule.
- On a key load, expands the cipher key into all 11 round keys, one per cycle, and holds them in registers.
- On request, streams them to the inverse-cipher datapath in reverse order (round 10 down to round 0) over a valid/ready handshake.
- Sits between the key input of the decryption top and its round datapath.

Parameters:
- NR, 10, number of AES rounds. Fixed at 10 (AES-128); no other value is supported.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset.
- kld  input  1  key load strobe; key is sampled when kld=1.
- key  input  128  cipher key. key[127:96] is word w0; key[31:0] is w3.
- key_ready  output  1  all 11 round keys are valid in storage.
- rd_start  input  1  request one reverse-order stream of round keys.
- rk_valid  output  1  rk_out/rk_round/rk_last are valid.
- rk_ready  input  1  consumer accepts the current round key.
- rk_out  output  128  round key, same word ordering as key.
- rk_round  output  4  round index of rk_out, 10..0.
- rk_last  output  1  high with the round-0 key.
- busy  output  1  high in EXPAND or STREAM.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; key_ready=0, rk_valid=0, rk_last=0, busy=0, rk_round=0, rk_out=0.
  - Storage contents are don't-care; key_ready=0 marks them invalid.
  - Reset overrides kld and rd_start in the same cycle.
- State machine: IDLE, EXPAND, READY, STREAM.
- kld=1 in any state (takes priority over rd_start and over the handshake):
  - rk[0] <= key; exp_cnt <= 1; state <= EXPAND.
  - key_ready <= 0, rk_valid <= 0, busy <= 1.
  - A stream in progress is aborted with no further transfer.
- EXPAND:
  - Each edge writes rk[exp_cnt] from rk[exp_cnt-1]:
    - t = SubWord(RotWord(w3)) ^ {rcon[exp_cnt], 24'h0}
    - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - SubWord uses four instances of the team's existing combinational aes_sbox.
  - On the edge writing rk[10]: state <= READY, key_ready <= 1, busy <= 0.
  - Timing: kld sampled at edge E0; key_ready reads 1 after edge E0+10.
- rd_start:
  - Ignored in IDLE, EXPAND and STREAM (no queuing).
  - In READY: state <= STREAM, idx <= 10, rk_valid <= 1, busy <= 1.
  - First key is visible the cycle after the rd_start edge.
- STREAM:
  - rk_out = rk[idx], rk_round = idx, rk_last = (idx==0).
  - Outputs hold stable while rk_valid=1 and rk_ready=0.
  - Transfer happens on an edge with rk_valid&&rk_ready=1.
    - idx>0: idx <= idx-1; rk_valid stays 1, giving back-to-back transfers (11 cycles minimum when rk_ready is held high).
    - idx==0: rk_valid <= 0, rk_last <= 0, state <= READY, busy <= 0.
- After a stream completes, key_ready stays 1; further rd_start pulses replay the same keys without re-expanding.
- Arithmetic is pure XOR/byte substitution; no carries and no width growth.

Test Plan:
- Reset with kld=1 and rd_start=1 held, rst=0 -> outputs all 0 and state IDLE after release; rd_start in IDLE -> rk_valid stays 0.
- kld with key=2b7e151628aed2a6abf7158809cf4f3c -> key_ready rises exactly 10 cycles after the kld edge.
- rd_start, then rk_ready=1 held, on the key above:
  - first transfer: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6
  - second-to-last transfer: rk_round=1, rk_out=a0fafe1788542cb123a339392a6c7605
  - last transfer: rk_round=0, rk_last=1, rk_out=key
  - 11 transfers in 11 consecutive cycles.
- Random rk_ready backpressure -> rk_out/rk_round stable while stalled; the sequence 10..0 is delivered with no skips or duplicates.
- kld asserted mid-stream at rk_round=6 with key=000102030405060708090a0b0c0d0e0f:
  - next cycle: rk_valid=0, key_ready=0.
  - after re-expansion, streamed round-10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- rd_start asserted during EXPAND and during STREAM -> ignored; a second rd_start after completion replays the identical 11 keys.
